// File: rtl/fir_seq_ctrl.sv
// Job sequencer for the serial-MAC FIR engine: clears the data RAM, then for each sample
// accepts the input, steps TAP_NUM MAC cycles, waits out the datapath and hands off the result.
module fir_seq_ctrl #(
    parameter int TAP_NUM     = 11,
    parameter int PIPE_LAT    = 3,
    parameter int pADDR_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ap_start,
    input  logic [31:0]            data_length,
    output logic                   ap_idle,
    output logic                   ap_done,
    input  logic                   ss_tvalid,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic                   sm_tlast,
    output logic                   data_we,
    output logic [pADDR_WIDTH-1:0] data_addr,
    output logic [pADDR_WIDTH-1:0] tap_addr,
    output logic                   mac_en,
    output logic                   mac_clr,
    output logic                   err_tlast
);
    localparam int AW     = pADDR_WIDTH;
    localparam int STAGES = PIPE_LAT - 1;
    localparam logic [AW-1:0] LAST_K = AW'(TAP_NUM - 1);
    localparam logic [AW:0]   TAPS   = (AW+1)'(TAP_NUM);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_WAIT_IN, S_MAC, S_DRAIN, S_OUT, S_DONE
    } state_t;

    state_t        state;
    logic [31:0]   len;
    logic [31:0]   in_cnt;
    logic [31:0]   out_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] step;
    logic [STAGES:0] vld_pipe;

    logic          ss_hs;
    logic          sm_hs;
    logic          in_last;
    logic          out_last;
    logic          last_mac;
    logic [AW:0]   mac_diff;
    logic [AW-1:0] mac_addr;

    assign ss_hs    = (state == S_WAIT_IN) && ss_tvalid;
    assign sm_hs    = (state == S_OUT) && sm_tready;
    assign in_last  = (in_cnt == len - 32'd1);
    assign out_last = (out_cnt == len - 32'd1);
    assign last_mac = (state == S_MAC) && (step == LAST_K);

    // Newest sample sits at wr_ptr, so tap k pairs with the sample k positions older.
    assign mac_diff = {1'b0, wr_ptr} + TAPS - {1'b0, step};
    assign mac_addr = (mac_diff >= TAPS) ? AW'(mac_diff - TAPS) : AW'(mac_diff);

    assign ap_idle   = (state == S_IDLE);
    assign ap_done   = (state == S_DONE);
    assign ss_tready = (state == S_WAIT_IN);
    assign sm_tvalid = (state == S_OUT);
    assign sm_tlast  = (state == S_OUT) && out_last;
    assign mac_en    = (state == S_MAC);
    assign mac_clr   = (state == S_MAC) && (step == '0);
    assign tap_addr  = (state == S_MAC) ? step : '0;
    assign data_we   = (state == S_CLEAR) || ss_hs;

    always_comb begin
        data_addr = '0;
        case (state)
            S_CLEAR:   data_addr = step;
            S_WAIT_IN: data_addr = wr_ptr;
            S_MAC:     data_addr = mac_addr;
            default:   data_addr = '0;
        endcase
    end

    // One-hot marker of the last MAC step travelling through the datapath latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= (vld_pipe << 1) | (STAGES+1)'(last_mac);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            len       <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            wr_ptr    <= '0;
            step      <= '0;
            err_tlast <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        len       <= data_length;
                        err_tlast <= 1'b0;
                        in_cnt    <= '0;
                        out_cnt   <= '0;
                        wr_ptr    <= '0;
                        step      <= '0;
                        state     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (step == LAST_K) begin
                        step  <= '0;
                        state <= (len == 32'd0) ? S_DONE : S_WAIT_IN;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                S_WAIT_IN: begin
                    if (ss_hs) begin
                        if (ss_tlast != in_last) err_tlast <= 1'b1;
                        in_cnt <= in_cnt + 32'd1;
                        step   <= '0;
                        state  <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (step == LAST_K) begin
                        step  <= '0;
                        state <= S_DRAIN;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (vld_pipe[STAGES]) state <= S_OUT;
                end
                S_OUT: begin
                    if (sm_hs) begin
                        wr_ptr  <= (wr_ptr == LAST_K) ? '0 : wr_ptr + 1'b1;
                        out_cnt <= out_cnt + 32'd1;
                        state   <= out_last ? S_DONE : S_WAIT_IN;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Randomized bench for fir_seq_ctrl: a monitor logs RAM/MAC/stream activity per job and
// the job-level model derives the expected address walk, tlast, latency and error flag.
module tb_fir_seq_ctrl;
    localparam int T  = 11;
    localparam int P  = 3;
    localparam int AW = 4;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          ap_start = 0;
    logic [31:0]   data_length = 0;
    logic          ap_idle, ap_done;
    logic          ss_tvalid = 0, ss_tlast = 0, ss_tready;
    logic          sm_tvalid, sm_tready = 0, sm_tlast;
    logic          data_we, mac_en, mac_clr, err_tlast;
    logic [AW-1:0] data_addr, tap_addr;

    fir_seq_ctrl #(.TAP_NUM(T), .PIPE_LAT(P), .pADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .ap_start(ap_start), .data_length(data_length),
        .ap_idle(ap_idle), .ap_done(ap_done), .ss_tvalid(ss_tvalid), .ss_tlast(ss_tlast),
        .ss_tready(ss_tready), .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tlast(sm_tlast),
        .data_we(data_we), .data_addr(data_addr), .tap_addr(tap_addr), .mac_en(mac_en),
        .mac_clr(mac_clr), .err_tlast(err_tlast)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // Monitor: logs per-job activity at the falling edge.
    int cyc = 0, in_hs = 0, out_hs = 0, done_cnt = 0, rdy_cyc = 0;
    int wr_q[$], mac_q[$], in_t[$], out_t[$], last_q[$];
    bit sm_seen = 0, p_v = 0, p_r = 0, p_l = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (data_we) wr_q.push_back(int'(data_addr));
            if (mac_en) mac_q.push_back(int'(mac_clr) * 256 + int'(tap_addr) * 16 + int'(data_addr));
            if (ss_tready) rdy_cyc++;
            if (ss_tvalid && ss_tready) begin
                in_t.push_back(cyc);
                in_hs++;
            end
            if (p_v && !p_r) begin
                chk("sm_hold_valid", sm_tvalid, 1);
                chk("sm_hold_last", sm_tlast, p_l);
            end
            if (sm_tvalid) begin
                chk("ss_rdy_during_out", ss_tready, 0);
                if (!sm_seen) begin
                    out_t.push_back(cyc);
                    sm_seen = 1;
                end
                if (sm_tready) begin
                    last_q.push_back(int'(sm_tlast));
                    out_hs++;
                    sm_seen = 0;
                end
            end
            if (ap_done) begin
                done_cnt++;
                chk("idle_in_done", ap_idle, 0);
            end
            p_v = sm_tvalid;
            p_r = sm_tready;
            p_l = sm_tlast;
        end else begin
            p_v = 0;
            sm_seen = 0;
        end
    end

    task automatic clear_log();
        wr_q.delete(); mac_q.delete(); in_t.delete(); out_t.delete(); last_q.delete();
        in_hs = 0; out_hs = 0; done_cnt = 0; rdy_cyc = 0;
    endtask

    // len samples; tlast driven on sample index tl_idx; stall holds sm_tready low >20 cycles per
    // output; poke fires ap_start mid-job, which must change nothing.
    task automatic run_job(input int len, input int tl_idx, input bit stall, input bit poke);
        int issued = 0, vc = 0, budget, exp;
        bit poked = 0;
        clear_log();
        budget = 60 * len + 200;
        @(posedge clk); #1;
        ap_start = 1; data_length = len;
        @(posedge clk); #1;
        ap_start = 0; data_length = $urandom;
        @(negedge clk);
        chk("idle_after_start", ap_idle, 0);
        chk("err_cleared", err_tlast, 0);
        for (int c = 0; c < budget && done_cnt == 0; c++) begin
            @(posedge clk); #1;
            if (ss_tvalid && in_hs == issued) begin
                ss_tvalid = 0;
                ss_tlast  = 0;
            end
            if (!ss_tvalid && issued < len && $urandom_range(0, 2) != 0) begin
                ss_tvalid = 1;
                ss_tlast  = (issued == tl_idx);
                issued++;
            end
            vc = sm_tvalid ? vc + 1 : 0;
            sm_tready = stall ? (vc > 20) : ($urandom_range(0, 3) != 0);
            if (poke && !poked && in_hs == 1) begin
                ap_start = 1; data_length = len + 5; poked = 1;
            end else begin
                ap_start = 0;
            end
        end
        ap_start = 0; ss_tvalid = 0; ss_tlast = 0; sm_tready = 0;
        chk("job_done", done_cnt, 1);
        @(negedge clk);
        chk("idle_after_done", ap_idle, 1);
        chk("done_one_cycle", done_cnt, 1);

        chk("wr_count", wr_q.size(), T + len);
        for (int i = 0; i < wr_q.size() && i < T + len; i++) begin
            exp = (i < T) ? i : (i - T) % T;
            chk("wr_addr", wr_q[i], exp);
        end
        chk("mac_count", mac_q.size(), T * len);
        for (int n = 0; n < mac_q.size() && n < T * len; n++) begin
            int i = n / T, k = n % T;
            exp = (k == 0 ? 256 : 0) + k * 16 + ((i % T) - k + T) % T;
            chk("mac_step", mac_q[n], exp);
        end
        chk("out_count", last_q.size(), len);
        for (int j = 0; j < last_q.size(); j++)
            chk("sm_tlast", last_q[j], (j == len - 1) ? 1 : 0);
        for (int i = 0; i < in_t.size() && i < out_t.size(); i++)
            chk("in_to_out_latency", out_t[i] - in_t[i], T + P + 1);
        chk("err_tlast", err_tlast, (len > 0 && tl_idx != len - 1) ? 1 : 0);
        if (len == 0) chk("no_ss_ready", rdy_cyc, 0);
    endtask

    task automatic reset_mid_mac();
        int c = 0;
        clear_log();
        @(posedge clk); #1;
        ap_start = 1; data_length = 8;
        @(posedge clk); #1;
        ap_start = 0; ss_tvalid = 1; ss_tlast = 0; sm_tready = 1;
        while (in_hs < 5 && c < 1000) begin
            @(posedge clk); #1;
            c++;
        end
        chk("reach_sample5", in_hs, 5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("in_mac_before_rst", mac_en, 1);
        rst_n = 0;
        #1;
        chk("rst_idle", ap_idle, 1);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_data_we", data_we, 0);
        chk("rst_ss_tready", ss_tready, 0);
        chk("rst_sm_tvalid", sm_tvalid, 0);
        chk("rst_ap_done", ap_done, 0);
        ss_tvalid = 0; sm_tready = 0;
        @(negedge clk);
        rst_n = 1;
        chk("rst_no_done", done_cnt, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_idle", ap_idle, 1);
        chk("reset_strobes", {ap_done, ss_tready, sm_tvalid, sm_tlast, data_we, mac_en, mac_clr}, 0);
        chk("reset_err", err_tlast, 0);
        rst_n = 1;

        run_job(3, 2, 0, 0);
        run_job(12, 11, 0, 0);
        run_job(4, 3, 1, 0);
        run_job(0, 0, 0, 0);
        run_job(4, 1, 0, 0);
        run_job(2, 1, 0, 1);
        reset_mid_mac();
        run_job(5, 4, 0, 1);
        repeat (6) begin
            int len = $urandom_range(1, 14);
            int tl  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : len - 1;
            run_job(len, tl, bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
